// File: rtl/seg7_scan_decoder.sv
// Snoops a scanned 7-segment bus, debounces each digit slot and decodes it back to hex.
// A complete set of slots is offered as one frame on a valid/ready output port.
module seg7_scan_decoder #(
    parameter int NDIG   = 4,
    parameter int STABLE = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic [NDIG-1:0]       dig_sel,
    output logic [4*NDIG-1:0]     hex_out,
    output logic [NDIG-1:0]       dig_err,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  overrun
);

    localparam int SW = 7 + NDIG;
    localparam int CW = $clog2(STABLE + 1);

    // Handshake: a frame transfers on every rising edge where frame_valid && frame_ready;
    // hex_out/dig_err stay frozen while frame_valid is high and not yet accepted.
    typedef enum logic {COLLECT = 1'b0, PRESENT = 1'b1} state_t;

    state_t               state, state_nx;
    logic [SW-1:0]        s_q;
    logic [CW-1:0]        stab_cnt;
    logic [NDIG-1:0]      seen, cap_seen;
    logic [4*NDIG-1:0]    work_hex, cap_hex;
    logic [NDIG-1:0]      work_err, cap_err;
    logic [6:0]           q_seg;
    logic [NDIG-1:0]      q_dig;
    logic                 capture, frame_done, load, drop;
    logic                 dec_hit;
    logic [3:0]           dec_nib;

    assign q_seg = s_q[SW-1:NDIG];
    assign q_dig = s_q[NDIG-1:0];

    // The counter saturates at STABLE, so a long stable run captures exactly once.
    assign capture = (stab_cnt == CW'(STABLE - 1)) && $onehot(q_dig);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q      <= '0;
            stab_cnt <= '0;
        end else begin
            s_q <= {seg_in, dig_sel};
            if ({seg_in, dig_sel} == s_q) begin
                if (stab_cnt != CW'(STABLE))
                    stab_cnt <= stab_cnt + CW'(1);
            end else begin
                stab_cnt <= '0;
            end
        end
    end

    always_comb begin
        dec_hit = 1'b1;
        dec_nib = 4'h0;
        case (q_seg)
            7'h7E: dec_nib = 4'h0;
            7'h30: dec_nib = 4'h1;
            7'h6D: dec_nib = 4'h2;
            7'h79: dec_nib = 4'h3;
            7'h33: dec_nib = 4'h4;
            7'h5B: dec_nib = 4'h5;
            7'h5F: dec_nib = 4'h6;
            7'h70: dec_nib = 4'h7;
            7'h7F: dec_nib = 4'h8;
            7'h7B: dec_nib = 4'h9;
            7'h77: dec_nib = 4'hA;
            7'h1F: dec_nib = 4'hB;
            7'h4E: dec_nib = 4'hC;
            7'h3D: dec_nib = 4'hD;
            7'h4F: dec_nib = 4'hE;
            7'h47: dec_nib = 4'hF;
            default: dec_hit = 1'b0;
        endcase
    end

    // Working set as it will be after this edge, including a slot captured now.
    always_comb begin
        cap_hex  = work_hex;
        cap_err  = work_err;
        cap_seen = seen;
        if (capture) begin
            for (int i = 0; i < NDIG; i++) begin
                if (q_dig[i]) begin
                    cap_hex[4*i +: 4] = dec_nib;
                    cap_err[i]        = ~dec_hit;
                    cap_seen[i]       = 1'b1;
                end
            end
        end
    end

    assign frame_done = capture && (&cap_seen);

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        drop     = 1'b0;
        case (state)
            COLLECT: begin
                if (frame_done) begin
                    load     = 1'b1;
                    state_nx = PRESENT;
                end
            end
            PRESENT: begin
                if (frame_done) begin
                    load = frame_ready;
                    drop = ~frame_ready;
                end else if (frame_ready) begin
                    state_nx = COLLECT;
                end
            end
            default: state_nx = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= COLLECT;
            seen     <= '0;
            work_hex <= '0;
            work_err <= '0;
            hex_out  <= '0;
            dig_err  <= '0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_nx;
            work_hex <= cap_hex;
            work_err <= cap_err;
            seen     <= frame_done ? '0 : cap_seen;
            overrun  <= drop;
            if (load) begin
                hex_out <= cap_hex;
                dig_err <= cap_err;
            end
        end
    end

    assign frame_valid = (state == PRESENT);

endmodule
